ln_arg_reduce: RTL

Range-reduction front end for the fully pipelined single-precision ln series datapath, which computes ln(1+t) ≈ t − t²/2 + t³/3 − t⁴/4 + t⁵/5 with a fixed latency and no stall. Accepts one IEEE-754 operand per cycle, splits it into an unbiased exponent and a series argument t = m − 1, drives t into the series pipeline, and carries exponent, class and valid through a delay line so they emerge aligned with the series result. A downstream combiner then forms the final result from these aligned outputs as e·ln2 + ln(1+t).

---
 rtl/ln_arg_reduce.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ln_arg_reduce.sv
// Range-reduction front end for the ln(1+t) series pipeline: splits an IEEE-754 single into exponent, class and t = m - 1.
// Optional LN_SQRT2_FOLD_EN folds mantissas >= sqrt(2) into negative t to keep |t| <= 0.415.
module ln_arg_reduce #(
   parameter int PIPE_LAT = 63
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_x,
   output logic [31:0] t_out,
   output logic        t_valid,
   output logic        tag_valid,
   output logic [8:0]  tag_exp,
   output logic [2:0]  tag_class
);

   localparam logic [2:0] CLS_NORMAL = 3'd0;
   localparam logic [2:0] CLS_ZERO   = 3'd1;
   localparam logic [2:0] CLS_NEG    = 3'd2;
   localparam logic [2:0] CLS_PINF   = 3'd3;
   localparam logic [2:0] CLS_NAN    = 3'd4;

   logic        x_sign;
   logic [7:0]  x_exp;
   logic [22:0] x_frac;
   logic [2:0]  cls_next;
   logic        fold_next;
   logic [8:0]  exp_next;
   logic [23:0] mag_next;

   logic        s1_valid;
   logic [2:0]  s1_class;
   logic        s1_fold;
   logic [8:0]  s1_exp;
   logic [23:0] s1_mag;

   logic [4:0]  lead;
   logic [22:0] norm;
   logic [7:0]  t_exp_field;
   logic [31:0] t_next;

   logic [8:0]  s2_exp;
   logic [2:0]  s2_class;

   logic [12:0] tag_pipe [PIPE_LAT];

   assign x_sign = in_x[31];
   assign x_exp  = in_x[30:23];
   assign x_frac = in_x[22:0];

   always_comb begin
      cls_next  = CLS_NORMAL;
      fold_next = 1'b0;
      exp_next  = 9'd0;
      mag_next  = 24'd0;
      if (x_exp == 8'hFF && x_frac != 23'd0) cls_next = CLS_NAN;
      else if (x_exp == 8'd0)                cls_next = CLS_ZERO;
      else if (x_sign)                       cls_next = CLS_NEG;
      else if (x_exp == 8'hFF)               cls_next = CLS_PINF;
      else                                   cls_next = CLS_NORMAL;
      if (cls_next == CLS_NORMAL) begin
`ifdef LN_SQRT2_FOLD_EN
         fold_next = (x_frac >= 23'h3504F3);
`endif
         if (fold_next) begin
            // m >= sqrt(2): represent m/2 instead, t = -(2^23 - F) * 2^-24
            exp_next = {1'b0, x_exp} - 9'd126;
            mag_next = 24'h800000 - {1'b0, x_frac};
         end else begin
            exp_next = {1'b0, x_exp} - 9'd127;
            mag_next = {1'b0, x_frac};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_class <= 3'd0;
         s1_fold  <= 1'b0;
         s1_exp   <= 9'd0;
         s1_mag   <= 24'd0;
      end else begin
         s1_valid <= in_valid;
         s1_class <= cls_next;
         s1_fold  <= fold_next;
         s1_exp   <= exp_next;
         s1_mag   <= mag_next;
      end
   end

   always_comb begin
      lead = 5'd0;
      for (int i = 0; i < 24; i++) begin
         if (s1_mag[i]) lead = i[4:0];
      end
      norm        = 23'(s1_mag << (5'd23 - lead));
      t_exp_field = (s1_fold ? 8'd103 : 8'd104) + {3'b000, lead};
      t_next      = (s1_mag == 24'd0) ? 32'h0000_0000 : {s1_fold, t_exp_field, norm};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         t_out    <= 32'd0;
         t_valid  <= 1'b0;
         s2_exp   <= 9'd0;
         s2_class <= 3'd0;
      end else begin
         t_out    <= t_next;
         t_valid  <= s1_valid;
         s2_exp   <= s1_exp;
         s2_class <= s1_class;
      end
   end

   // Delay line matches the series pipeline latency so tags land with the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PIPE_LAT; i++) tag_pipe[i] <= 13'd0;
      end else begin
         tag_pipe[0] <= {t_valid, s2_exp, s2_class};
         for (int i = 1; i < PIPE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      end
   end

   assign tag_valid = tag_pipe[PIPE_LAT-1][12];
   assign tag_exp   = tag_pipe[PIPE_LAT-1][11:3];
   assign tag_class = tag_pipe[PIPE_LAT-1][2:0];

endmodule
